teraisc_quad_decoder: RTL
=========================

// Module: teraisc_quad_decoder
// PURPOSE
//  Multi-channel x4 quadrature decoder for wheel/motor encoders. Per channel: synchronises A/B,
//  optionally filters them, decodes Gray steps to signed position and direction, flags illegal
//  transitions, and reports a velocity (steps per fixed window). Sits between encoder pins and the
//  Avalon-side control/PID registers. Everything runs on one system clock.
// PARAMETERS
//  NUM_CH      2      number of independent encoder channels (>=1)
//  CNT_W       16     position counter width, signed two's complement
//  VEL_W       16     velocity output width, signed, saturating
//  VEL_PERIOD  50000  window length in DI_SYSCLK cycles (>=2)
//  FILT_LEN    4      stable-sample count for glitch filter (>=1; used only with QDEC_FILTER_EN)
// PORTS
//  DI_SYSCLK     in   1             system clock; all logic on rising edge
//  DI_RESET      in   1             synchronous reset, active-high
//  DI_PHASE_A    in   NUM_CH        asynchronous encoder phase A, one bit per channel
//  DI_PHASE_B    in   NUM_CH        asynchronous encoder phase B
//  DI_CLR        in   NUM_CH        per-channel position clear, 1-cycle strobe
//  DI_ERR_CLR    in   1             clears all sticky error flags
//  DO_POS        out  NUM_CH*CNT_W  packed positions, ch0 in LSBs
//  DO_VEL        out  NUM_CH*VEL_W  packed signed step count of last completed window
//  DO_VEL_VALID  out  1             1-cycle strobe when DO_VEL updates (all channels together)
//  DO_PULSE      out  NUM_CH        1-cycle strobe per valid step
//  DO_DIRECT     out  NUM_CH        direction of last valid step: 1 = forward, 0 = reverse
//  DO_ERR        out  NUM_CH        sticky flag: illegal transition seen (A and B changed together)
// BEHAVIOUR
//  - Reset: DO_POS=0, DO_VEL=0, DO_VEL_VALID=0, DO_PULSE=0, DO_DIRECT=0, DO_ERR=0. Window counter=0.
//    Sync flops, filter state and the "primed" flag are cleared. Reset mid-window discards the partial window.
//  - Sync: 2-flop synchroniser per phase. Next stage: prev AB register plus primed flag.
//    First sample after reset loads prev AB, sets primed, and produces no step.
//  - Decode of prev->cur AB: 00->01->11->10->00 is forward (+1). The reverse order is -1.
//    No change: none. Both bits change: error, no count, DO_ERR set.
//  - Latency: pin edge to DO_PULSE/DO_POS update is 3 cycles without filter; see CONFIGURATION for filter.
//  - DO_POS wraps modulo 2^CNT_W (0x7FFF +1 -> 0x8000; 0 -1 -> 0xFFFF at CNT_W=16).
//  - DI_CLR has priority over a simultaneous step: DO_POS goes to 0, that step is not counted in position.
//    DO_PULSE, DO_DIRECT and velocity still register the step.
//  - DO_DIRECT holds its value until the next valid step. Error steps leave it unchanged.
//  - DO_ERR is set by an error step. DI_ERR_CLR clears it.
//    If set and clear land on the same cycle, set wins.
//  - Velocity window counter runs 0..VEL_PERIOD-1.
//    At terminal count: DO_VEL <= accumulator plus this cycle's step, saturated to +/-(2^(VEL_W-1)-1).
//    DO_VEL_VALID=1 for that cycle, accumulator reloads to 0. A step on the terminal cycle belongs to the ending window.
//  - The velocity accumulator saturates internally at the same bounds and never wraps.
// CONFIGURATION
//  QDEC_FILTER_EN defined: each synchronised phase passes through a FILT_LEN-deep stability filter.
//    The filtered bit changes only after FILT_LEN consecutive equal samples. Latency becomes 3+FILT_LEN cycles.
//    Pulses shorter than FILT_LEN cycles are suppressed.
//  QDEC_FILTER_EN undefined: filter absent; filtered = synchronised; FILT_LEN ignored; latency 3.
// STRUCTURE
//  - Package qdec_pkg holds:
//    - typedef enum {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR} qdec_step_t
//    - function qdec_decode(prev_ab, cur_ab) returning qdec_step_t
//    - localparams for saturation bounds
//  - Sub-module qdec_channel: sync, filter, decode, position, direction, error and velocity accumulator for one channel.
//    Instantiated NUM_CH times via generate.
//  - The top holds the shared window counter, drives a terminal-count strobe to all channels, and packs outputs.
// TESTING
//  1 Forward sequence 00,01,11,10,00 on ch0, each held 10 cycles -> DO_POS[ch0]=4, DO_DIRECT=1, 4 DO_PULSE strobes.
//    ch1 unchanged.
//  2 Reverse 8 steps from reset -> DO_POS=0xFFF8 (CNT_W=16), DO_DIRECT=0.
//    Then 0x8000 forward steps from 0x7FFF -> wraps to 0xFFFF.
//  3 AB 00->11 in one sample -> DO_ERR=1, DO_POS unchanged, no pulse.
//    DI_ERR_CLR same cycle as a new error -> DO_ERR stays 1.
//  4 VEL_PERIOD=100, 30 forward steps in one window -> DO_VEL=30 with DO_VEL_VALID at cycle 100.
//    Reset at cycle 50 of next window -> DO_VEL=0, no valid strobe.
//  5 DI_CLR asserted on the same cycle as a forward step -> DO_POS=0, DO_PULSE=1, window count includes the step.
//  6 With QDEC_FILTER_EN, FILT_LEN=4: 2-cycle glitch on A -> no step.
//    5-cycle level change -> step after 7 cycles.

Source files
------------

// File: rtl/qdec_pkg.sv
// Shared types and helpers for the quadrature decoder: step classification,
// Gray-step decode function and default velocity saturation bounds.
package qdec_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } qdec_step_t;

  // Saturation bounds for the default 16-bit velocity path; channels derive their own from VEL_W.
  localparam int unsigned QDEC_DEF_VEL_W = 16;
  localparam int QDEC_VEL_MAX = (1 << (QDEC_DEF_VEL_W - 1)) - 1;
  localparam int QDEC_VEL_MIN = -QDEC_VEL_MAX;

  // AB is packed {A,B}; 00->01->11->10->00 counts forward.
  function automatic qdec_step_t qdec_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    qdec_step_t step;
    case ({prev_ab, cur_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step = STEP_FWD;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step = STEP_REV;
      default: step = (prev_ab == cur_ab) ? STEP_NONE : STEP_ERR;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/qdec_channel.sv
// One quadrature channel: synchroniser, optional glitch filter (QDEC_FILTER_EN),
// step decode, position, direction, sticky error and velocity accumulator.
module qdec_channel
  import qdec_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned VEL_W    = 16
`ifdef QDEC_FILTER_EN
  ,
  parameter int unsigned FILT_LEN = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_a,
  input  logic             phase_b,
  input  logic             clr,
  input  logic             err_clr,
  input  logic             win_tc,
  output logic [CNT_W-1:0] pos,
  output logic [VEL_W-1:0] vel,
  output logic             pulse,
  output logic             direct,
  output logic             err
);

  localparam logic signed [VEL_W:0] VEL_MAX_X = {2'b00, {(VEL_W - 1){1'b1}}};
  localparam logic signed [VEL_W:0] VEL_MIN_X = -VEL_MAX_X;

  logic [1:0] sync1, sync2, filt_ab, prev_ab;
  logic       primed;
  qdec_step_t step;

  logic signed [VEL_W-1:0] acc, acc_next;
  logic signed [VEL_W:0]   delta, sum_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {phase_a, phase_b};
      sync2 <= sync1;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int unsigned FCW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  logic [FCW-1:0] filt_cnt [2];

  // Each bit follows its input only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_ab <= '0;
      for (int unsigned i = 0; i < 2; i++) filt_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != filt_ab[i]) begin
          if (filt_cnt[i] == FCW'(FILT_LEN - 1)) begin
            filt_ab[i]  <= sync2[i];
            filt_cnt[i] <= '0;
          end else begin
            filt_cnt[i] <= filt_cnt[i] + FCW'(1);
          end
        end else begin
          filt_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign filt_ab = sync2;
`endif

  always_comb begin
    step = primed ? qdec_decode(prev_ab, filt_ab) : STEP_NONE;
    delta = '0;
    if (step == STEP_FWD) delta = (VEL_W + 1)'(1);
    if (step == STEP_REV) delta = '1;
    sum_ext = $signed({acc[VEL_W-1], acc}) + delta;
    if (sum_ext > VEL_MAX_X)      acc_next = VEL_MAX_X[VEL_W-1:0];
    else if (sum_ext < VEL_MIN_X) acc_next = VEL_MIN_X[VEL_W-1:0];
    else                          acc_next = sum_ext[VEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab <= '0;
      primed  <= 1'b0;
      pos     <= '0;
      pulse   <= 1'b0;
      direct  <= 1'b0;
      err     <= 1'b0;
      acc     <= '0;
      vel     <= '0;
    end else begin
      prev_ab <= filt_ab;
      primed  <= 1'b1;
      pulse   <= (step == STEP_FWD) || (step == STEP_REV);
      if (step == STEP_FWD) direct <= 1'b1;
      if (step == STEP_REV) direct <= 1'b0;
      // Clear wins over a coincident step for position only.
      if (clr)                   pos <= '0;
      else if (step == STEP_FWD) pos <= pos + CNT_W'(1);
      else if (step == STEP_REV) pos <= pos - CNT_W'(1);
      if (step == STEP_ERR) err <= 1'b1;
      else if (err_clr)     err <= 1'b0;
      if (win_tc) begin
        vel <= acc_next;
        acc <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

endmodule

// File: rtl/teraisc_quad_decoder.sv
// Multi-channel x4 quadrature decoder: shared velocity window plus NUM_CH channels.
// Define QDEC_FILTER_EN to insert a FILT_LEN-sample glitch filter on each phase.
module teraisc_quad_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned VEL_W      = 16,
  parameter int unsigned VEL_PERIOD = 50000,
  parameter int unsigned FILT_LEN   = 4
) (
  input  logic                    DI_SYSCLK,
  input  logic                    DI_RESET,
  input  logic [NUM_CH-1:0]       DI_PHASE_A,
  input  logic [NUM_CH-1:0]       DI_PHASE_B,
  input  logic [NUM_CH-1:0]       DI_CLR,
  input  logic                    DI_ERR_CLR,
  output logic [NUM_CH*CNT_W-1:0] DO_POS,
  output logic [NUM_CH*VEL_W-1:0] DO_VEL,
  output logic                    DO_VEL_VALID,
  output logic [NUM_CH-1:0]       DO_PULSE,
  output logic [NUM_CH-1:0]       DO_DIRECT,
  output logic [NUM_CH-1:0]       DO_ERR
);

  localparam int unsigned WCW = (VEL_PERIOD < 2) ? 1 : $clog2(VEL_PERIOD);

  if (NUM_CH < 1 || VEL_PERIOD < 2 || FILT_LEN < 1) begin : g_bad_param
    $error("teraisc_quad_decoder: illegal parameter value");
  end

  logic [WCW-1:0] win_cnt;
  logic           win_tc;

  assign win_tc = (win_cnt == WCW'(VEL_PERIOD - 1));

  always_ff @(posedge DI_SYSCLK) begin
    if (DI_RESET) begin
      win_cnt      <= '0;
      DO_VEL_VALID <= 1'b0;
    end else begin
      win_cnt      <= win_tc ? '0 : win_cnt + WCW'(1);
      DO_VEL_VALID <= win_tc;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    qdec_channel #(
      .CNT_W    (CNT_W),
      .VEL_W    (VEL_W)
`ifdef QDEC_FILTER_EN
      ,
      .FILT_LEN (FILT_LEN)
`endif
    ) u_ch (
      .clk     (DI_SYSCLK),
      .rst     (DI_RESET),
      .phase_a (DI_PHASE_A[ch]),
      .phase_b (DI_PHASE_B[ch]),
      .clr     (DI_CLR[ch]),
      .err_clr (DI_ERR_CLR),
      .win_tc  (win_tc),
      .pos     (DO_POS[ch*CNT_W +: CNT_W]),
      .vel     (DO_VEL[ch*VEL_W +: VEL_W]),
      .pulse   (DO_PULSE[ch]),
      .direct  (DO_DIRECT[ch]),
      .err     (DO_ERR[ch])
    );
  end

endmodule
